// File: rtl/yu_decode_pkg.sv
// Shared decode definitions: base opcodes, format codes and opcode-to-format classification.
// Later pipeline stages import this so every stage agrees on the encoding tables.
package yu_decode_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  // Anything without the 32-bit encoding marker or with an unknown opcode is illegal.
  function automatic fmt_e fmt_of(input logic [31:0] instr);
    fmt_e f;
    f = FMT_ILL;
    if (instr[1:0] == 2'b11) begin
      case (instr[6:0])
        OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: f = FMT_I;
        OPC_STORE:                                  f = FMT_S;
        OPC_BRANCH:                                 f = FMT_B;
        OPC_LUI, OPC_AUIPC:                         f = FMT_U;
        OPC_JAL:                                    f = FMT_J;
        OPC_OP:                                     f = FMT_R;
        default:                                    f = FMT_ILL;
      endcase
    end
    return f;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: raw instruction to sign-extended immediate,
// format code and illegal flag.
module imm_gen
  import yu_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  fmt_e        fmt_sel;
  logic [31:0] imm32;

  // Every immediate fits in 32 bits; widening to XLEN is a plain sign extension.
  always_comb begin
    fmt_sel = fmt_of(instr);
    imm32   = '0;
    case (fmt_sel)
      FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'b0};
      FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm     = XLEN'($signed(imm32));
  assign fmt     = fmt_sel;
  assign illegal = (fmt_sel == FMT_ILL);

endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage: instruction FIFO in front of a registered decoded-output bundle.
// An instruction presented in cycle n is visible on the outputs in cycle n+2.
module instr_decode_stage
  import yu_decode_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_f3,
  output logic [6:0]      out_f7,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]     instr_mem [QUEUE_DEPTH];
  logic [XLEN-1:0] pc_mem    [QUEUE_DEPTH];

  logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg, count_next;
  logic            in_ready_reg;
  logic            push, pop;

  logic [31:0]     head_instr;
  logic [XLEN-1:0] head_pc;
  logic [XLEN-1:0] head_imm;
  logic [2:0]      head_fmt;
  logic            head_illegal;

  logic            out_valid_reg;
  logic [31:0]     out_instr_reg;
  logic [XLEN-1:0] out_imm_reg;
  logic [2:0]      out_fmt_reg;
  logic            out_illegal_reg;
  logic [XLEN-1:0] out_pc_reg;

  // in_ready is a flop, so the fetch side never sees a path from out_ready.
  assign push = in_valid & in_ready_reg;
  assign pop  = (count_reg != '0) & (~out_valid_reg | out_ready);

  assign head_instr = instr_mem[rd_ptr_reg];
  assign head_pc    = pc_mem[rd_ptr_reg];

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr   (head_instr),
    .imm     (head_imm),
    .fmt     (head_fmt),
    .illegal (head_illegal)
  );

  always_comb begin
    count_next = count_reg;
    if (flush) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  // Storage has no reset: occupancy is tracked solely by count_reg.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      instr_mem[wr_ptr_reg] <= in_instr;
      pc_mem[wr_ptr_reg]    <= in_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      in_ready_reg    <= 1'b0;
      out_valid_reg   <= 1'b0;
      out_instr_reg   <= '0;
      out_imm_reg     <= '0;
      out_fmt_reg     <= '0;
      out_illegal_reg <= 1'b0;
      out_pc_reg      <= '0;
    end else begin
      count_reg    <= count_next;
      in_ready_reg <= (count_next < CW'(QUEUE_DEPTH));
      if (flush) begin
        wr_ptr_reg    <= '0;
        rd_ptr_reg    <= '0;
        out_valid_reg <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr_reg <= wr_ptr_reg + PW'(1);
        end
        if (pop) begin
          rd_ptr_reg      <= rd_ptr_reg + PW'(1);
          out_valid_reg   <= 1'b1;
          out_instr_reg   <= head_instr;
          out_imm_reg     <= head_imm;
          out_fmt_reg     <= head_fmt;
          out_illegal_reg <= head_illegal;
          out_pc_reg      <= head_pc;
        end else if (out_ready) begin
          out_valid_reg <= 1'b0;
        end
      end
    end
  end

  assign in_ready    = in_ready_reg;
  assign out_valid   = out_valid_reg;
  assign out_opcode  = out_instr_reg[6:0];
  assign out_f3      = out_instr_reg[14:12];
  assign out_f7      = out_instr_reg[31:25];
  assign out_rs1     = out_instr_reg[19:15];
  assign out_rs2     = out_instr_reg[24:20];
  assign out_rd      = out_instr_reg[11:7];
  assign out_imm     = out_imm_reg;
  assign out_fmt     = out_fmt_reg;
  assign out_illegal = out_illegal_reg;
  assign out_pc      = out_pc_reg;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: directed scenarios plus randomized traffic, checked by a
// scoreboard fed from an arithmetic reference decoder.
module tb_instr_decode_stage;

  localparam int XLEN = 32;
  localparam int QD   = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     in_instr = '0;
  logic [XLEN-1:0] in_pc = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [6:0]      out_opcode;
  logic [2:0]      out_f3;
  logic [6:0]      out_f7;
  logic [4:0]      out_rs1, out_rs2, out_rd;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;
  logic [XLEN-1:0] out_pc;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
    logic [XLEN-1:0] pc;
  } bundle_t;

  bundle_t exp_q[$];

  instr_decode_stage #(.XLEN(XLEN), .QUEUE_DEPTH(QD)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_f3(out_f3), .out_f7(out_f7),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  // Reference decoder: immediates rebuilt as signed integer sums of the encoded pieces.
  function automatic bundle_t model(input logic [31:0] i, input logic [XLEN-1:0] p);
    bundle_t b;
    longint  v;
    int      f;
    v = 0;
    f = 7;
    if (i[1:0] == 2'b11) begin
      case (i[6:0])
        7'h03, 7'h13, 7'h67, 7'h73: begin f = 1; v = longint'($signed(i)) >>> 20; end
        7'h23: begin
          f = 2;
          v = (longint'($signed(i)) >>> 25) * 64'sd32 + longint'(i[11:7]);
        end
        7'h63: begin
          f = 3;
          v = (i[31] ? -64'sd4096 : 64'sd0) + longint'(i[7]) * 64'sd2048
            + longint'(i[30:25]) * 64'sd32 + longint'(i[11:8]) * 64'sd2;
        end
        7'h37, 7'h17: begin f = 4; v = longint'($signed(i & 32'hFFFF_F000)); end
        7'h6F: begin
          f = 5;
          v = (i[31] ? -64'sd1048576 : 64'sd0) + longint'(i[19:12]) * 64'sd4096
            + longint'(i[20]) * 64'sd2048 + longint'(i[30:21]) * 64'sd2;
        end
        7'h33: begin f = 0; v = 0; end
        default: f = 7;
      endcase
    end
    if (f == 7) v = 0;
    b.opcode  = i[6:0];
    b.f3      = i[14:12];
    b.f7      = i[31:25];
    b.rs1     = i[19:15];
    b.rs2     = i[24:20];
    b.rd      = i[11:7];
    b.imm     = v[XLEN-1:0];
    b.fmt     = f[2:0];
    b.illegal = (f == 7);
    b.pc      = p;
    return b;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 11))
      0:  r[6:0] = 7'h03;
      1:  r[6:0] = 7'h13;
      2:  r[6:0] = 7'h67;
      3:  r[6:0] = 7'h73;
      4:  r[6:0] = 7'h23;
      5:  r[6:0] = 7'h63;
      6:  r[6:0] = 7'h37;
      7:  r[6:0] = 7'h17;
      8:  r[6:0] = 7'h6F;
      9:  r[6:0] = 7'h33;
      10: r[6:0] = 7'h0B;
      default: r[1:0] = 2'($urandom_range(0, 2));
    endcase
    return r;
  endfunction

  // Monitor: records accepted instructions and checks every completed transfer.
  initial begin : monitor
    bundle_t exp, act;
    int txn;
    txn = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          act = '{out_opcode, out_f3, out_f7, out_rs1, out_rs2, out_rd,
                  out_imm, out_fmt, out_illegal, out_pc};
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL spurious_bundle: got pc=%h opcode=%h with nothing expected", out_pc, out_opcode);
          end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
              errors++;
              $display("FAIL bundle %0d: got pc=%h op=%h imm=%h fmt=%0d ill=%0d raw=%h, required pc=%h op=%h imm=%h fmt=%0d ill=%0d raw=%h",
                       txn, act.pc, act.opcode, act.imm, act.fmt, act.illegal, act,
                       exp.pc, exp.opcode, exp.imm, exp.fmt, exp.illegal, exp);
            end else begin
              $display("txn %0d pc=%h op=%h rd=%0d imm=%h fmt=%0d ill=%0d ok",
                       txn, act.pc, act.opcode, act.rd, act.imm, act.fmt, act.illegal);
            end
          end
          txn++;
        end
        if (flush) exp_q.delete();
        else if (in_valid && in_ready) exp_q.push_back(model(in_instr, in_pc));
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Returns one time unit after the edge that accepted the instruction.
  task automatic send(input logic [31:0] i, input logic [XLEN-1:0] p);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_instr = i;
    in_pc    = p;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      done = in_ready;
      cycle();
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for 40 cycles required acceptance of %h", i);
    end
  endtask

  task automatic check_head(input string name, input logic [2:0] f, input logic [XLEN-1:0] imm,
                            input logic [4:0] rd, input logic ill);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (out_valid) seen = 1'b1;
      else cycle();
    end
    chk({name, "_valid"}, 128'(seen), 128'(1'b1));
    chk(name, {out_fmt, out_illegal, out_rd, out_imm}, {f, ill, rd, imm});
    if (seen && out_ready) cycle();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no end of test required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int acc, run, seen_valid;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {out_valid, out_opcode, out_f3, out_f7, out_rs1, out_rs2, out_rd,
                          out_imm, out_fmt, out_illegal, out_pc}, '0);
    #3;
    rst = 1'b0;
    cycle();
    chk("reset_in_ready", 128'(in_ready), 128'(1'b1));

    // Two-cycle latency and field extraction for an addi
    out_ready = 1'b1;
    send(32'hFFF1_0093, 32'h100);
    chk("lat_after_accept", 128'(out_valid), 128'(1'b0));
    cycle();
    chk("lat_two_cycles", 128'(out_valid), 128'(1'b1));
    chk("addi_fields", {out_opcode, out_rd, out_rs1, out_imm, out_fmt, out_pc},
        {7'h13, 5'd1, 5'd2, 32'hFFFF_FFFF, 3'd1, 32'h100});
    cycle();

    // Branch and LUI immediates
    send(32'hFE00_0EE3, 32'h104);
    check_head("branch", 3'd3, 32'hFFFF_FFFC, 5'd29, 1'b0);
    send(32'h1234_52B7, 32'h108);
    check_head("lui", 3'd4, 32'h1234_5000, 5'd5, 1'b0);

    // Illegal word between two legal ones
    send(32'h0050_0093, 32'h200);
    check_head("ill_pre", 3'd1, 32'h5, 5'd1, 1'b0);
    send(32'h0000_0000, 32'h204);
    check_head("ill_zero", 3'd7, 32'h0, 5'd0, 1'b1);
    send(32'h4020_8033, 32'h208);
    check_head("ill_post", 3'd0, 32'h0, 5'd0, 1'b0);

    // Fill with consumer stalled: buffer plus output register
    out_ready = 1'b0;
    acc = 0;
    in_valid = 1'b1;
    in_instr = rand_instr();
    in_pc = 32'h300;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (in_ready) acc++;
      cycle();
      in_instr = rand_instr();
      in_pc = in_pc + 32'd4;
    end
    in_valid = 1'b0;
    chk("full_accepted", 128'(acc), 128'(QD + 1));
    chk("full_in_ready_low", 128'(in_ready), 128'(1'b0));
    out_ready = 1'b1;
    run = 0;
    for (int k = 0; k < QD + 1; k++) begin
      @(negedge clk);
      if (out_valid) run++;
    end
    chk("full_back_to_back", 128'(run), 128'(QD + 1));
    @(negedge clk);
    chk("full_drained", 128'(out_valid), 128'(1'b0));
    cycle();

    // Flush with three buffered entries and a coincident push
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(rand_instr(), 32'h400 + 32'(k * 4));
    in_valid = 1'b1;
    in_instr = 32'h0010_0093;
    in_pc = 32'h4F0;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 128'(out_valid), 128'(1'b0));
    out_ready = 1'b1;
    seen_valid = 0;
    for (int k = 0; k < 4; k++) begin
      if (out_valid) seen_valid++;
      cycle();
    end
    chk("flush_nothing_emitted", 128'(seen_valid), 128'(0));
    send(32'h0020_0113, 32'h500);
    chk("flush_next_lat1", 128'(out_valid), 128'(1'b0));
    cycle();
    chk("flush_next_lat2", {out_valid, out_pc}, {1'b1, 32'h500});
    cycle();

    // Asynchronous reset while full
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_instr = rand_instr();
      in_pc = 32'h600 + 32'(k * 4);
      cycle();
    end
    in_valid = 1'b0;
    chk("rst_pre_full", 128'(in_ready), 128'(1'b0));
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", {out_valid, out_opcode, out_f3, out_f7, out_rs1, out_rs2, out_rd,
                              out_imm, out_fmt, out_illegal, out_pc}, '0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    cycle();
    chk("rst_release", {in_ready, out_valid}, {1'b1, 1'b0});

    // Randomized traffic with occasional flush
    for (int k = 0; k < 1500; k++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_instr  = rand_instr();
      in_pc     = $urandom() & ~32'h3;
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 49) == 0);
      cycle();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) cycle();
    cycle();
    chk("drain_scoreboard", 128'(exp_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
